// File: rtl/fdiv_ctrl_if.sv
// Operand/result stream bundle for fdiv_ctrl; flag signals exist only when FDIV_FLAGS_EN is defined.
interface fdiv_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_q;
`ifdef FDIV_FLAGS_EN
   logic        out_overflow;
   logic        out_underflow;

   modport master (output in_valid, in_a, in_b, out_ready,
                   input  in_ready, out_valid, out_q, out_overflow, out_underflow);
   modport slave  (input  in_valid, in_a, in_b, out_ready,
                   output in_ready, out_valid, out_q, out_overflow, out_underflow);
`else
   modport master (output in_valid, in_a, in_b, out_ready,
                   input  in_ready, out_valid, out_q);
   modport slave  (input  in_valid, in_a, in_b, out_ready,
                   output in_ready, out_valid, out_q);
`endif
endinterface

// File: rtl/fdiv_ctrl.sv
// Single-precision divide q = a * finv(b): dividend tag pipeline, rounded multiply, credit-limited output FIFO.
// Optional FDIV_FLAGS_EN adds per-entry overflow/underflow flags.
module fdiv_ctrl #(
   parameter int unsigned FINV_LAT  = 2,
   parameter int unsigned OUT_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   fdiv_ctrl_if.slave  io,
   output logic [31:0] finv_s,
   input  logic [31:0] finv_d
);
   localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
   localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
   localparam int unsigned LAST  = FINV_LAT - 1;
`ifdef FDIV_FLAGS_EN
   localparam int unsigned ENT_W = 34;
`else
   localparam int unsigned ENT_W = 32;
`endif

   logic                acc, push, pop;
   logic [CNT_W-1:0]    cnt, occ, occ_next;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic                out_valid_r;
   logic [ENT_W-1:0]    mem [OUT_DEPTH];
   logic [ENT_W-1:0]    ent;
   logic [FINV_LAT-1:0] tag_v, tag_bz;
   logic [31:0]         tag_a [FINV_LAT];

   logic [31:0]         a_t;
   logic                b_zero, a_zero, sign, norm, g, rb, st, rnd_up;
   logic [47:0]         prod;
   logic [23:0]         m24;
   logic [24:0]         m25;
   logic [22:0]         frac;
   logic signed [9:0]   e_fin;
   logic [31:0]         q_res;

   assign finv_s      = io.in_b;
   assign io.in_ready = rstn && (cnt < CNT_W'(OUT_DEPTH));
   assign acc         = io.in_valid && io.in_ready;
   assign push        = tag_v[LAST];
   assign pop         = out_valid_r && io.out_ready;

   // Tag valids: the only state that decides whether a finv_d is consumed.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         tag_v <= '0;
      end else begin
         tag_v[0] <= acc;
         for (int i = 1; i < FINV_LAT; i++) tag_v[i] <= tag_v[i-1];
      end
   end

   always_ff @(posedge clk) begin
      tag_a[0]  <= io.in_a;
      tag_bz[0] <= (io.in_b[30:23] == 8'h00);
      for (int i = 1; i < FINV_LAT; i++) begin
         tag_a[i]  <= tag_a[i-1];
         tag_bz[i] <= tag_bz[i-1];
      end
   end

   // Rounded multiply of the aligned dividend by the reciprocal.
   always_comb begin
      a_t    = tag_a[LAST];
      b_zero = tag_bz[LAST];
      a_zero = (a_t[30:23] == 8'h00);
      sign   = a_t[31] ^ finv_d[31];
      prod   = 48'({1'b1, a_t[22:0]}) * 48'({1'b1, finv_d[22:0]});
      norm   = prod[47];
      m24    = norm ? prod[47:24] : prod[46:23];
      g      = norm ? prod[23] : prod[22];
      rb     = norm ? prod[22] : prod[21];
      st     = norm ? (|prod[21:0]) : (|prod[20:0]);
      rnd_up = g & (rb | st | m24[0]);
      m25    = {1'b0, m24} + 25'(rnd_up);
      frac   = m25[24] ? m25[23:1] : m25[22:0];
      e_fin  = $signed({2'b00, a_t[30:23]}) + $signed({2'b00, finv_d[30:23]}) - 10'sd127
               + $signed({9'b0, norm}) + $signed({9'b0, m25[24]});
      q_res  = {sign, e_fin[7:0], frac};
      if (b_zero)                q_res = {sign, 8'hFF, 23'h0};
      else if (a_zero)           q_res = {sign, 31'h0};
      else if (e_fin >= 10'sd255) q_res = {sign, 8'hFF, 23'h0};
      else if (e_fin <= 10'sd0)   q_res = {sign, 31'h0};
   end

`ifdef FDIV_FLAGS_EN
   logic ovf, unf;
   assign ovf = b_zero || (!a_zero && (e_fin >= 10'sd255));
   assign unf = !b_zero && !a_zero && (e_fin <= 10'sd0);
   assign ent = {ovf, unf, q_res};
`else
   assign ent = q_res;
`endif

   assign occ_next = occ + CNT_W'(push) - CNT_W'(pop);

   // Credit counter covers tags in flight plus FIFO occupancy, so pushes never overflow.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt         <= '0;
         occ         <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         out_valid_r <= 1'b0;
      end else begin
         cnt         <= cnt + CNT_W'(acc) - CNT_W'(pop);
         occ         <= occ_next;
         out_valid_r <= (occ_next != '0);
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= ent;
   end

   assign io.out_valid = out_valid_r;
   assign io.out_q     = out_valid_r ? mem[rd_ptr][31:0] : 32'h0;
`ifdef FDIV_FLAGS_EN
   assign io.out_overflow  = out_valid_r && mem[rd_ptr][33];
   assign io.out_underflow = out_valid_r && mem[rd_ptr][32];
`endif
endmodule

// File: tb/tb_fdiv_ctrl.sv
// Self-checking bench for fdiv_ctrl: bench-side finv model, arithmetic reference divider, credit model.
module tb_fdiv_ctrl;
   localparam int unsigned FINV_LAT  = 2;
   localparam int unsigned OUT_DEPTH = 4;
`ifdef FDIV_FLAGS_EN
   localparam logic [33:0] CMP_MASK = 34'h3_FFFF_FFFF;
`else
   localparam logic [33:0] CMP_MASK = 34'h0_FFFF_FFFF;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] finv_s, finv_d;
   logic        r_ovr_en;
   logic [31:0] r_ovr, cur_r;
   logic [31:0] rpipe [FINV_LAT];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [33:0] exp_q[$];
   logic [33:0] got_q[$];

   always #5 clk = ~clk;

   fdiv_ctrl_if io();

   fdiv_ctrl #(.FINV_LAT(FINV_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .rstn(rstn), .io(io), .finv_s(finv_s), .finv_d(finv_d)
   );

   // Bench reciprocal unit: exact for powers of two, a fixed approximation otherwise.
   function automatic logic [31:0] finv_model(input logic [31:0] b);
      int e;
      if (b[30:23] == 8'h00) return {b[31], 8'hFF, 23'h0};
      if (b[22:0] == 23'h0) begin
         e = 254 - int'(b[30:23]);
         return {b[31], 8'(e), 23'h0};
      end
      e = 253 - int'(b[30:23]);
      return {b[31], 8'(e), ~b[22:0]};
   endfunction

   // Reference quotient {overflow, underflow, q} using integer rounding of the exact product.
   function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] r, input logic [31:0] b);
      logic s;
      longint unsigned ma, mr, p, m, rem, half;
      int e, sh;
      s = a[31] ^ r[31];
      if (b[30:23] == 8'h00) return {2'b10, s, 8'hFF, 23'h0};
      if (a[30:23] == 8'h00) return {2'b00, s, 31'h0};
      ma = 64'(a[22:0]) + (64'd1 << 23);
      mr = 64'(r[22:0]) + (64'd1 << 23);
      p  = ma * mr;
      e  = int'(a[30:23]) + int'(r[30:23]) - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin
         sh = 24;
         e++;
      end
      m    = p >> sh;
      rem  = p - (m << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m++;
      if (m == (64'd1 << 24)) begin
         m = m >> 1;
         e++;
      end
      if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
      if (e <= 0)   return {2'b01, s, 31'h0};
      return {2'b00, s, 8'(e), m[22:0]};
   endfunction

   function automatic logic [33:0] head_word();
`ifdef FDIV_FLAGS_EN
      return {io.out_overflow, io.out_underflow, io.out_q};
`else
      return {2'b00, io.out_q};
`endif
   endfunction

   function automatic logic [31:0] rand_fp(input int lo, input int hi);
      return {1'($urandom), 8'($urandom_range(hi, lo)), 23'($urandom)};
   endfunction

   always_comb cur_r = r_ovr_en ? r_ovr : finv_model(finv_s);
   assign finv_d = rpipe[FINV_LAT-1];

   always @(posedge clk) begin
      rpipe[0] <= cur_r;
      for (int i = 1; i < FINV_LAT; i++) rpipe[i] <= rpipe[i-1];
   end

   // Called at the negedge: log handshakes into the scoreboard, then move to just after the next posedge.
   task automatic step();
      if (io.in_valid && io.in_ready) exp_q.push_back(ref_div(io.in_a, cur_r, io.in_b));
      if (io.out_valid && io.out_ready) got_q.push_back(head_word());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; io.in_valid = 1'b1; io.in_a = 32'h3F800000; io.in_b = 32'h3F800000;
      io.out_ready = 1'b0; r_ovr_en = 1'b0; r_ovr = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      n_tests++; if (io.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", io.in_ready); end
      n_tests++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", io.out_valid); end
      n_tests++; if (io.out_q !== 32'h0) begin n_fail++; $display("FAIL reset_out_q got=%h exp=0", io.out_q); end
      step();
      rstn = 1'b1; io.in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", io.in_ready); end
      step();
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_single();
      io.in_valid = 1'b1; io.in_a = 32'h40C00000; io.in_b = 32'h40000000; io.out_ready = 1'b1;
      @(negedge clk);
      n_tests++; if (finv_s !== 32'h40000000) begin n_fail++; $display("FAIL single_finv_s got=%h exp=40000000", finv_s); end
      n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got=%b exp=1", io.in_ready); end
      step();
      io.in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         n_tests++;
         if (io.out_valid !== (c == 3)) begin
            n_fail++; $display("FAIL single_out_valid cycle=%0d got=%b exp=%b", c, io.out_valid, (c == 3));
         end
         if (c == 3) begin
            n_tests++; if (io.out_q !== 32'h40400000) begin n_fail++; $display("FAIL single_out_q got=%h exp=40400000", io.out_q); end
         end
         step();
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_stream();
      io.out_ready = 1'b1;
      for (int c = 0; c < 22; c++) begin
         io.in_valid = (c < 16);
         io.in_a = rand_fp(64, 190);
         io.in_b = rand_fp(64, 190);
         @(negedge clk);
         if (c < 16) begin
            n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cycle=%0d got=%b exp=1", c, io.in_ready); end
         end
         n_tests++;
         if (io.out_valid !== (c >= 3 && c < 19)) begin
            n_fail++; $display("FAIL stream_out_valid cycle=%0d got=%b exp=%b", c, io.out_valid, (c >= 3 && c < 19));
         end
         step();
      end
      io.in_valid = 1'b0;
      n_tests++; if (got_q.size() != 16) begin n_fail++; $display("FAIL stream_count got=%0d exp=16", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_tests++;
         if ((got_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
            n_fail++; $display("FAIL stream_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_back_pressure();
      int accepts = 0;
      logic [31:0] held_q = 32'h0;
      logic held = 1'b0;
      io.out_ready = 1'b0; io.in_valid = 1'b1;
      for (int c = 0; c < 9; c++) begin
         io.in_a = rand_fp(100, 150);
         io.in_b = rand_fp(100, 150);
         @(negedge clk);
         if (io.in_ready) accepts++;
         if (c >= 4) begin
            n_tests++; if (io.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, io.in_ready); end
         end
         if (io.out_valid && !held) begin held = 1'b1; held_q = io.out_q; end
         else if (held) begin
            n_tests++; if (io.out_q !== held_q) begin n_fail++; $display("FAIL bp_hold cycle=%0d got=%h exp=%h", c, io.out_q, held_q); end
         end
         step();
      end
      n_tests++; if (accepts != int'(OUT_DEPTH)) begin n_fail++; $display("FAIL bp_accepts got=%0d exp=%0d", accepts, OUT_DEPTH); end
      io.in_valid = 1'b0; io.out_ready = 1'b1;
      for (int d = 0; d < 10 && got_q.size() < 4; d++) begin
         @(negedge clk);
         if (d == 0) begin
            n_tests++; if (io.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid got=%b exp=1", io.out_valid); end
            n_tests++; if (io.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_same_cycle_credit got=%b exp=0", io.in_ready); end
         end
         if (d == 1) begin
            n_tests++; if (io.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_credit_return got=%b exp=1", io.in_ready); end
         end
         step();
      end
      n_tests++; if (got_q.size() != 4) begin n_fail++; $display("FAIL bp_drain_count got=%0d exp=4", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_tests++;
         if ((got_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
            n_fail++; $display("FAIL bp_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   // Issue one pair with out_ready high and wait (bounded) for its result.
   task automatic one_op(input logic [31:0] a, input logic [31:0] b, output logic [33:0] res, output logic ok);
      io.out_ready = 1'b1; io.in_valid = 1'b1; io.in_a = a; io.in_b = b;
      @(negedge clk);
      step();
      io.in_valid = 1'b0;
      ok = 1'b0; res = 34'h0;
      for (int w = 0; w < 10 && !ok; w++) begin
         @(negedge clk);
         if (io.out_valid) begin ok = 1'b1; res = head_word(); end
         step();
      end
   endtask

   task automatic test_special();
      logic [31:0] ta [3] = '{32'h3F800000, 32'h00000000, 32'h7F000000};
      logic [31:0] tb [3] = '{32'h00000000, 32'h40000000, 32'h00800000};
      logic [33:0] te [3] = '{34'h2_7F800000, 34'h0_00000000, 34'h2_7F800000};
      logic [33:0] res;
      logic ok;
      for (int i = 0; i < 3; i++) begin
         one_op(ta[i], tb[i], res, ok);
         n_tests++;
         if (!ok || ((res & CMP_MASK) !== (te[i] & CMP_MASK))) begin
            n_fail++; $display("FAIL special idx=%0d got=%h exp=%h seen=%b", i, res, te[i], ok);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_rounding();
      logic [31:0] ta [4] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00000, 32'h3FFFFFFF};
      logic [31:0] tr [4] = '{32'h3F800001, 32'h3F800003, 32'h3F800001, 32'h3F800001};
      logic [31:0] te [4] = '{32'h3F800002, 32'h3FC00004, 32'h3FC00002, 32'h40000000};
      logic [33:0] res;
      logic ok;
      r_ovr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         r_ovr = tr[i];
         one_op(ta[i], 32'h3F800000, res, ok);
         n_tests++;
         if (!ok || res[31:0] !== te[i]) begin
            n_fail++; $display("FAIL rounding idx=%0d got=%h exp=%h seen=%b", i, res[31:0], te[i], ok);
         end
      end
      r_ovr_en = 1'b0;
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_midflight();
      logic [33:0] res, want;
      logic ok;
      io.out_ready = 1'b0; io.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         io.in_a = rand_fp(100, 150); io.in_b = rand_fp(100, 150);
         @(negedge clk);
         step();
      end
      io.in_valid = 1'b0; rstn = 1'b0;
      @(negedge clk);
      n_tests++; if (io.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=0", io.in_ready); end
      step();
      rstn = 1'b1; io.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_tests++; if (io.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale cycle=%0d got=%b exp=0", c, io.out_valid); end
         step();
      end
      exp_q.delete(); got_q.delete();
      want = ref_div(32'h41000000, finv_model(32'h40800000), 32'h40800000);
      one_op(32'h41000000, 32'h40800000, res, ok);
      n_tests++;
      if (!ok || (res & CMP_MASK) !== (want & CMP_MASK)) begin
         n_fail++; $display("FAIL midrst_new got=%h exp=%h seen=%b", res, want, ok);
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_random();
      int outstanding;
      for (int c = 0; c < 300; c++) begin
         io.in_valid  = ($urandom_range(3, 0) != 0);
         io.out_ready = ($urandom_range(2, 0) != 0);
         io.in_a = rand_fp(0, 254);
         io.in_b = ($urandom_range(15, 0) == 0) ? {1'($urandom), 31'h0} : rand_fp(1, 253);
         @(negedge clk);
         outstanding = exp_q.size() - got_q.size();
         n_tests++;
         if (io.in_ready !== (outstanding < int'(OUT_DEPTH))) begin
            n_fail++; $display("FAIL rand_credit cycle=%0d got=%b exp=%b", c, io.in_ready, (outstanding < int'(OUT_DEPTH)));
         end
         step();
      end
      io.in_valid = 1'b0; io.out_ready = 1'b1;
      for (int d = 0; d < 20 && got_q.size() < exp_q.size(); d++) begin
         @(negedge clk);
         step();
      end
      n_tests++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_tests++;
         if ((got_q[i] & CMP_MASK) !== (exp_q[i] & CMP_MASK)) begin
            n_fail++; $display("FAIL rand_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      exp_q.delete(); got_q.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_back_pressure();
      test_special();
      test_rounding();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
